// File: rtl/write_buffer_fwd.sv
// Posted-write buffer in front of a single bus master port. Writes are queued and acked at once,
// then drained in FIFO order; reads bypass the queue under a selectable hazard policy.
module write_buffer_fwd #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int READ_MODE  = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    output logic                      o_empty,
    output logic                      o_full,
    output logic [$clog2(DEPTH):0]    o_queued,
    output logic                      o_bus_rw,
    output logic                      o_bus_request,
    input  logic                      i_bus_ready,
    output logic [ADDR_WIDTH-1:0]     o_bus_address,
    output logic [DATA_WIDTH/8-1:0]   o_bus_wmask,
    input  logic [DATA_WIDTH-1:0]     i_bus_rdata,
    output logic [DATA_WIDTH-1:0]     o_bus_wdata,
    input  logic                      i_rw,
    input  logic                      i_request,
    output logic                      o_ready,
    input  logic [ADDR_WIDTH-1:0]     i_address,
    input  logic [DATA_WIDTH/8-1:0]   i_wmask,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic [DATA_WIDTH-1:0]     o_rdata
);
    localparam int MW  = DATA_WIDTH / 8;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int LSB = $clog2(MW);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACK_WRITE = 3'd1,
        S_READ_BUS  = 3'd2,
        S_FWD_READ  = 3'd3,
        S_DRAIN     = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
    logic [MW-1:0]           mask_q [DEPTH];
    logic [DATA_WIDTH-1:0]   data_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   fwd_data_q;
    logic                    rd_done_q;
    logic                    push_s, pop_s, full_s, empty_s;
    logic                    hit_s, fwd_hit_s, read_ok_s;
    logic [PW-1:0]           hit_idx_s;

    assign empty_s  = (count_q == CW'(0));
    assign full_s   = (count_q == CW'(DEPTH));
    assign o_empty  = empty_s;
    assign o_full   = full_s;
    assign o_queued = count_q;

    // Associative compare, walking oldest to newest so the newest match wins
    always_comb begin
        logic [PW-1:0] idx_v;
        logic          match_v;
        hit_s     = 1'b0;
        hit_idx_s = '0;
        idx_v     = '0;
        match_v   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_v     = rd_ptr_q + PW'(i);
            match_v   = (CW'(i) < count_q) &&
                        (addr_q[idx_v][ADDR_WIDTH-1:LSB] == i_address[ADDR_WIDTH-1:LSB]);
            hit_idx_s = match_v ? idx_v : hit_idx_s;
            hit_s     = hit_s | match_v;
        end
    end

    // Read admission under the configured hazard policy
    always_comb begin
        fwd_hit_s = (READ_MODE == 2) && hit_s && (&mask_q[hit_idx_s]);
        case (READ_MODE)
            0:       read_ok_s = empty_s;
            1:       read_ok_s = !hit_s;
            default: read_ok_s = !hit_s || fwd_hit_s;
        endcase
    end

    // Next-state logic and queue push/pop strobes
    always_comb begin
        state_d = state_q;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_request && i_rw && !full_s) begin
                    push_s  = 1'b1;
                    state_d = S_ACK_WRITE;
                end else if (i_request && !i_rw && read_ok_s) begin
                    state_d = fwd_hit_s ? S_FWD_READ : S_READ_BUS;
                end else if (!empty_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK_WRITE, S_READ_BUS, S_FWD_READ: begin
                if (!i_request) state_d = S_IDLE;
                else            state_d = state_q;
            end
            S_DRAIN: begin
                if (i_bus_ready) begin
                    pop_s   = 1'b1;
                    state_d = S_GAP;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Entry count bookkeeping
    always_comb begin
        if (push_s)     count_d = count_q + CW'(1);
        else if (pop_s) count_d = count_q - CW'(1);
        else            count_d = count_q;
    end

    // State, queue storage, pointers and read-side capture
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fwd_data_q <= '0;
            rd_done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push_s) begin
                addr_q[wr_ptr_q] <= i_address;
                mask_q[wr_ptr_q] <= i_wmask;
                data_q[wr_ptr_q] <= i_wdata;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
            else       rd_ptr_q <= rd_ptr_q;
            if (state_q == S_IDLE && state_d == S_FWD_READ) fwd_data_q <= data_q[hit_idx_s];
            else                                            fwd_data_q <= fwd_data_q;
            // The bus read is one-shot; the host may hold i_request a cycle past completion
            if (state_q != S_READ_BUS)  rd_done_q <= 1'b0;
            else if (i_bus_ready)       rd_done_q <= 1'b1;
            else                        rd_done_q <= rd_done_q;
        end
    end

    // Host and bus outputs decoded from state; bus outputs stay zero without a request
    always_comb begin
        o_ready       = 1'b0;
        o_rdata       = '0;
        o_bus_rw      = 1'b0;
        o_bus_request = 1'b0;
        o_bus_address = '0;
        o_bus_wmask   = '0;
        o_bus_wdata   = '0;
        case (state_q)
            S_ACK_WRITE: o_ready = 1'b1;
            S_FWD_READ: begin
                o_ready = 1'b1;
                o_rdata = fwd_data_q;
            end
            S_READ_BUS: begin
                if (!rd_done_q) begin
                    o_bus_request = 1'b1;
                    o_bus_address = i_address;
                    o_bus_wmask   = '1;
                    o_ready       = i_bus_ready;
                    o_rdata       = i_bus_ready ? i_bus_rdata : '0;
                end else begin
                    o_bus_request = 1'b0;
                end
            end
            S_DRAIN: begin
                o_bus_request = 1'b1;
                o_bus_rw      = 1'b1;
                o_bus_address = addr_q[rd_ptr_q];
                o_bus_wmask   = mask_q[rd_ptr_q];
                o_bus_wdata   = data_q[rd_ptr_q];
            end
            default: o_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_write_buffer_fwd.sv
// Self-checking bench for write_buffer_fwd: vector table for host ops, a responding bus model
// with expected-transaction queues, and hand sequences for full-queue stall and mid-drain reset.
module tb_write_buffer_fwd;
    logic        clk;
    logic        i_reset;
    logic        o_empty, o_full;
    logic [2:0]  o_queued;
    logic        o_bus_rw, o_bus_request, i_bus_ready;
    logic [31:0] o_bus_address, i_bus_rdata, o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic        i_rw, i_request, o_ready;
    logic [31:0] i_address, i_wdata, o_rdata;
    logic [3:0]  i_wmask;

    int n_tests = 0;
    int n_fail  = 0;
    bit bus_hold = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  m;
        logic [31:0] d;
    } bus_t;
    bus_t        exp_wr[$];
    logic [31:0] exp_rd[$];

    typedef struct {
        logic        rw;
        logic        drain;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic        fwd;
        int          lat_min;
        int          lat_max;
    } vec_t;
    localparam int NV = 18;
    vec_t vecs[NV];

    write_buffer_fwd #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_MODE(2)) dut (
        .i_clock(clk), .i_reset(i_reset),
        .o_empty(o_empty), .o_full(o_full), .o_queued(o_queued),
        .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .i_bus_ready(i_bus_ready),
        .o_bus_address(o_bus_address), .o_bus_wmask(o_bus_wmask),
        .i_bus_rdata(i_bus_rdata), .o_bus_wdata(o_bus_wdata),
        .i_rw(i_rw), .i_request(i_request), .o_ready(o_ready),
        .i_address(i_address), .i_wmask(i_wmask), .i_wdata(i_wdata), .o_rdata(o_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bus_mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mk(input logic rw, input logic drain, input logic [31:0] a,
                                input logic [3:0] m, input logic [31:0] d, input logic [31:0] er,
                                input logic fwd, input int lmin, input int lmax);
        vec_t v;
        v.rw = rw; v.drain = drain; v.addr = a; v.mask = m; v.data = d;
        v.exp_rdata = er; v.fwd = fwd; v.lat_min = lmin; v.lat_max = lmax;
        return v;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        check(act === req, name, act, req);
    endtask

    // Drives one host op with i_request held until o_ready; lat counts cycles to o_ready
    task automatic host_op(input logic rw, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] d, output logic [31:0] rd, output int lat);
        @(negedge clk); #1;
        i_rw = rw; i_address = a; i_wmask = m; i_wdata = d; i_request = 1'b1;
        lat = 0;
        do begin
            @(negedge clk); #1;
            lat++;
        end while (!o_ready && lat < 200);
        rd = o_rdata;
        i_request = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(o_empty && !o_bus_request) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        check(n < 300, "drain_timeout", 32'(n), 32'd300);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Bus responder: completes each request at the first negedge it is seen, checks against queues
    initial begin
        bus_t e;
        bit   haz;
        i_bus_ready = 1'b0;
        i_bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (i_bus_ready) begin
                i_bus_ready = 1'b0;
                i_bus_rdata = '0;
                check_eq("bus_gap", 32'(o_bus_request), 32'd0);
            end else if (o_bus_request && !bus_hold && i_reset) begin
                if (o_bus_rw) begin
                    if (exp_wr.size() == 0) begin
                        check(1'b0, "unexpected_bus_write", o_bus_address, 32'd0);
                    end else begin
                        e = exp_wr.pop_front();
                        check_eq("bus_wr_addr", o_bus_address, e.a);
                        check_eq("bus_wr_mask", 32'(o_bus_wmask), 32'(e.m));
                        check_eq("bus_wr_data", o_bus_wdata, e.d);
                    end
                end else begin
                    check_eq("bus_rd_mask", 32'(o_bus_wmask), 32'hF);
                    if (exp_rd.size() == 0) check(1'b0, "unexpected_bus_read", o_bus_address, 32'd0);
                    else                    check_eq("bus_rd_addr", o_bus_address, exp_rd.pop_front());
                    haz = 1'b0;
                    foreach (exp_wr[k]) haz |= (exp_wr[k].a[31:2] == o_bus_address[31:2]);
                    check(!haz, "read_before_hit_drained", o_bus_address, 32'd0);
                    i_bus_rdata = bus_mem(o_bus_address);
                end
                i_bus_ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        bus_t        w;

        vecs[0]  = mk(1'b1, 1'b0, 32'h100, 4'hF, 32'h11,       32'h0,          1'b0, 1, 1);
        vecs[1]  = mk(1'b1, 1'b0, 32'h104, 4'hF, 32'h22,       32'h0,          1'b0, 1, 1);
        vecs[2]  = mk(1'b1, 1'b0, 32'h108, 4'hF, 32'h33,       32'h0,          1'b0, 1, 1);
        vecs[3]  = mk(1'b1, 1'b0, 32'h10C, 4'hF, 32'h44,       32'h0,          1'b0, 1, 1);
        vecs[4]  = mk(1'b1, 1'b1, 32'h200, 4'hF, 32'hDEADBEEF, 32'h0,          1'b0, 1, 1);
        vecs[5]  = mk(1'b0, 1'b0, 32'h200, 4'hF, 32'h0,        32'hDEADBEEF,   1'b1, 1, 1);
        vecs[6]  = mk(1'b1, 1'b1, 32'h300, 4'h3, 32'h5678,     32'h0,          1'b0, 1, 1);
        vecs[7]  = mk(1'b0, 1'b0, 32'h300, 4'hF, 32'h0,        bus_mem(32'h300), 1'b0, 2, 20);
        vecs[8]  = mk(1'b1, 1'b0, 32'h600, 4'hF, 32'hAA,       32'h0,          1'b0, 1, 1);
        vecs[9]  = mk(1'b0, 1'b0, 32'h400, 4'hF, 32'h0,        bus_mem(32'h400), 1'b0, 1, 1);
        vecs[10] = mk(1'b1, 1'b1, 32'h500, 4'hF, 32'h1,        32'h0,          1'b0, 1, 1);
        vecs[11] = mk(1'b1, 1'b0, 32'h500, 4'hF, 32'h2,        32'h0,          1'b0, 1, 1);
        vecs[12] = mk(1'b0, 1'b0, 32'h500, 4'hF, 32'h0,        32'h2,          1'b1, 1, 1);
        vecs[13] = mk(1'b1, 1'b1, 32'h700, 4'hF, 32'h77,       32'h0,          1'b0, 1, 1);
        vecs[14] = mk(1'b0, 1'b0, 32'h703, 4'hF, 32'h0,        32'h77,         1'b1, 1, 1);
        vecs[15] = mk(1'b1, 1'b1, 32'hA00, 4'hF, 32'hFF,       32'h0,          1'b0, 1, 1);
        vecs[16] = mk(1'b1, 1'b0, 32'hA00, 4'h1, 32'h01,       32'h0,          1'b0, 1, 1);
        vecs[17] = mk(1'b0, 1'b0, 32'hA00, 4'hF, 32'h0,        bus_mem(32'hA00), 1'b0, 2, 30);

        i_reset = 1'b0; i_rw = 1'b0; i_request = 1'b0;
        i_address = '0; i_wmask = '0; i_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_empty",   32'(o_empty), 32'd1);
        check_eq("rst_full",    32'(o_full), 32'd0);
        check_eq("rst_queued",  32'(o_queued), 32'd0);
        check_eq("rst_ready",   32'(o_ready), 32'd0);
        check_eq("rst_bus_req", 32'(o_bus_request), 32'd0);
        check_eq("rst_bus_adr", o_bus_address, 32'd0);
        check_eq("rst_rdata",   o_rdata, 32'd0);
        i_reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].drain) wait_drain();
            if (vecs[i].rw) begin
                w.a = vecs[i].addr; w.m = vecs[i].mask; w.d = vecs[i].data;
                exp_wr.push_back(w);
            end else if (!vecs[i].fwd) begin
                exp_rd.push_back(vecs[i].addr);
            end
            host_op(vecs[i].rw, vecs[i].addr, vecs[i].mask, vecs[i].data, rd, lat);
            check(lat >= vecs[i].lat_min && lat <= vecs[i].lat_max,
                  $sformatf("latency_v%0d", i), 32'(lat), 32'(vecs[i].lat_min));
            if (!vecs[i].rw) check_eq($sformatf("rdata_v%0d", i), rd, vecs[i].exp_rdata);
        end

        // Full queue with the bus stalled: the fifth write waits for a drain
        wait_drain();
        bus_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w.a = 32'h1000 + 32'(i * 4); w.m = 4'hF; w.d = 32'hC0DE_0000 + 32'(i);
            exp_wr.push_back(w);
        end
        for (int i = 0; i < 4; i++) begin
            host_op(1'b1, 32'h1000 + 32'(i * 4), 4'hF, 32'hC0DE_0000 + 32'(i), rd, lat);
            check_eq($sformatf("full_fill_lat%0d", i), 32'(lat), 32'd1);
        end
        fork
            host_op(1'b1, 32'h1010, 4'hF, 32'hC0DE_0004, rd, lat);
            begin
                repeat (6) @(negedge clk);
                #2;
                check_eq("full_flag",    32'(o_full), 32'd1);
                check_eq("full_queued",  32'(o_queued), 32'd4);
                check_eq("full_noready", 32'(o_ready), 32'd0);
                check_eq("full_busreq",  32'(o_bus_request), 32'd1);
                bus_hold = 1'b0;
            end
        join
        check(lat >= 6 && lat < 200, "full_write_lat", 32'(lat), 32'd6);

        // Reset asserted while a drain is on the bus
        wait_drain();
        bus_hold = 1'b1;
        w.a = 32'h800; w.m = 4'hF; w.d = 32'h88;
        exp_wr.push_back(w);
        host_op(1'b1, 32'h800, 4'hF, 32'h88, rd, lat);
        lat = 0;
        while (!o_bus_request && lat < 50) begin
            @(negedge clk); #1;
            lat++;
        end
        check(lat < 50, "drain_start", 32'(lat), 32'd50);
        i_reset = 1'b0;
        #1;
        check_eq("t1_bus_req", 32'(o_bus_request), 32'd0);
        check_eq("t1_empty",   32'(o_empty), 32'd1);
        check_eq("t1_queued",  32'(o_queued), 32'd0);
        exp_wr.delete();
        bus_hold = 1'b0;
        @(negedge clk);
        #1;
        i_reset = 1'b1;

        w.a = 32'h900; w.m = 4'hF; w.d = 32'h99;
        exp_wr.push_back(w);
        host_op(1'b1, 32'h900, 4'hF, 32'h99, rd, lat);
        check_eq("post_rst_wlat", 32'(lat), 32'd1);
        host_op(1'b0, 32'h900, 4'hF, 32'h0, rd, lat);
        check_eq("post_rst_fwd", rd, 32'h99);

        wait_drain();
        check_eq("left_writes", 32'(exp_wr.size()), 32'd0);
        check_eq("left_reads",  32'(exp_rd.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
